// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg -- shared definitions for the SD sector-channel arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE / ISSUE / XFER)
//   LBA_W_DEF   : default sector address width
//   DATA_W      : user_io buffer data width
//   TIMEOUT_DEF : default ISSUE-state ack watchdog in clocks
package sd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2
    } arb_state_e;

    localparam int LBA_W_DEF   = 32;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_DEF = 1 << 20;

endpackage

// File: rtl/sd_arbiter_rr_pick.sv
// rr_pick -- combinational N-bit round-robin priority encoder.
//   req_i [N]  : request vector
//   ptr_i [PW] : index of the last served channel; search starts at ptr_i+1
//   gnt_o [N]  : one-hot winner (0 when nothing requests)
//   idx_o [PW] : binary index of the winner
//   vld_o      : any request present
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          vld_o
);

    always_comb begin
        int          j;
        logic [PW-1:0] jj;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        jj    = '0;
        // Walk ptr+1 .. ptr+N (mod N); first hit wins, so the last
        // served channel has the lowest priority.
        for (int k = 1; k <= N; k++) begin
            j  = (int'(ptr_i) + k) % N;
            jj = PW'(j);
            if (!vld_o && req_i[jj]) begin
                vld_o     = 1'b1;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
            end
        end
    end

endmodule

// File: rtl/sd_arbiter.sv
// sd_arbiter -- shares the single user_io SD-sector channel between N
// block requesters, one sector transfer at a time, round-robin.
//   clock, reset(async, active-low)
//   reqRd/reqWr [N]     : per-channel level requests, held until chanAck
//   reqLba [N*LBA_W]    : per-channel LBA, channel i at [i*LBA_W +: LBA_W]
//   reqBuffD [N*8]      : per-channel buffer read data
//   chanAck/chanBuffW   : host ack / buffer-write strobe routed to owner only
//   hostRd/hostWr [N]   : to user_io sd_rd/sd_wr, at most one bit set
//   hostLba, hostBuffD  : to user_io sd_lba / sd_din
//   hostAck, hostBuffW  : from user_io sd_ack / sd_dout_strobe
//   grant [N]           : one-hot owner, 0 when idle
//   busy                : FSM not idle
//   timeout             : one-clock pulse on watchdog abort
// Optional feature: define SD_ARB_TIMEOUT_EN to enable the ISSUE-state
// ack watchdog; without it ISSUE waits forever and timeout is tied 0.
module sd_arbiter
    import sd_arb_pkg::*;
#(
    parameter int N       = 3,
    parameter int LBA_W   = LBA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N-1:0]        reqRd,
    input  logic [N-1:0]        reqWr,
    input  logic [N*LBA_W-1:0]  reqLba,
    input  logic [N*DATA_W-1:0] reqBuffD,
    output logic [N-1:0]        chanAck,
    output logic [N-1:0]        chanBuffW,
    output logic [N-1:0]        hostRd,
    output logic [N-1:0]        hostWr,
    output logic [LBA_W-1:0]    hostLba,
    output logic [DATA_W-1:0]   hostBuffD,
    input  logic                hostAck,
    input  logic                hostBuffW,
    output logic [N-1:0]        grant,
    output logic                busy,
    output logic                timeout
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    arb_state_e         state_q;
    logic [N-1:0]       grant_q;
    logic [PW-1:0]      ch_q;
    logic [PW-1:0]      ptr_q;
    logic [N-1:0]       host_rd_q;
    logic [N-1:0]       host_wr_q;
    logic [LBA_W-1:0]   lba_q;
    logic               timeout_q;

    logic [LBA_W-1:0]   lba_a  [N];
    logic [DATA_W-1:0]  buff_a [N];

    logic [N-1:0]       pick_gnt;
    logic [PW-1:0]      pick_idx;
    logic               pick_vld;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign lba_a[i]  = reqLba[i*LBA_W +: LBA_W];
        assign buff_a[i] = reqBuffD[i*DATA_W +: DATA_W];
    end

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req_i (reqRd | reqWr),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

`ifdef SD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ch_q      <= '0;
            ptr_q     <= PW'(N - 1);   // channel 0 is served first
            host_rd_q <= '0;
            host_wr_q <= '0;
            lba_q     <= '0;
            timeout_q <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick_gnt;
                        ch_q    <= pick_idx;
                        lba_q   <= lba_a[pick_idx];
                        // read wins when one channel asserts both
                        if (reqRd[pick_idx]) host_rd_q <= pick_gnt;
                        else                 host_wr_q <= pick_gnt;
                        state_q <= ST_ISSUE;
`ifdef SD_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                ST_ISSUE: begin
`ifdef SD_ARB_TIMEOUT_EN
                    cnt_q <= cnt_q + CW'(1);
`endif
                    if (hostAck) begin
                        host_rd_q <= '0;
                        host_wr_q <= '0;
                        state_q   <= ST_XFER;
                    end else if (!(reqRd[ch_q] | reqWr[ch_q])) begin
                        // requester gave up: abort without advancing the pointer
                        host_rd_q <= '0;
                        host_wr_q <= '0;
                        grant_q   <= '0;
                        state_q   <= ST_IDLE;
                    end
`ifdef SD_ARB_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        // TIMEOUT-th edge after ISSUE entry with no ack
                        host_rd_q <= '0;
                        host_wr_q <= '0;
                        grant_q   <= '0;
                        ptr_q     <= ch_q;
                        timeout_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
`endif
                end
                ST_XFER: begin
                    if (!hostAck) begin
                        grant_q <= '0;
                        ptr_q   <= ch_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Buffer-side routing is combinational so byte strobes line up with
    // user_io's own timing; grant_q gates everything while idle.
    always_comb begin
        hostBuffD = '0;
        if (|grant_q) hostBuffD = buff_a[ch_q];
    end

    assign chanAck   = {N{hostAck}}   & grant_q;
    assign chanBuffW = {N{hostBuffW}} & grant_q;
    assign hostRd    = host_rd_q;
    assign hostWr    = host_wr_q;
    assign hostLba   = lba_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_sd_arbiter.sv
module tb_sd_arbiter;

    localparam int N     = 3;
    localparam int LBA_W = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     reqRd, reqWr;
    logic [N*32-1:0]  reqLba;
    logic [N*8-1:0]   reqBuffD;
    logic [N-1:0]     chanAck, chanBuffW, hostRd, hostWr, grant;
    logic [31:0]      hostLba;
    logic [7:0]       hostBuffD;
    logic             hostAck, hostBuffW, busy, timeout;

    int checks = 0;
    int errors = 0;

    sd_arbiter #(.N(N), .LBA_W(LBA_W), .TIMEOUT(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .reqRd     (reqRd),
        .reqWr     (reqWr),
        .reqLba    (reqLba),
        .reqBuffD  (reqBuffD),
        .chanAck   (chanAck),
        .chanBuffW (chanBuffW),
        .hostRd    (hostRd),
        .hostWr    (hostWr),
        .hostLba   (hostLba),
        .hostBuffD (hostBuffD),
        .hostAck   (hostAck),
        .hostBuffW (hostBuffW),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // one complete transfer starting from IDLE with requests pending
    task automatic do_xfer(input string tag, input logic [2:0] g);
        tick();
        chk({tag, ".grant"}, 64'(grant), 64'(g));
        chk({tag, ".hostRd"}, 64'(hostRd), 64'(g));
        hostAck = 1'b1;
        tick();
        chk({tag, ".chanAck"}, 64'(chanAck), 64'(g));
        chk({tag, ".rdclr"}, 64'(hostRd), 64'd0);
        hostAck = 1'b0;
        tick();
        chk({tag, ".idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic seen;
        reset = 1'b0; reqRd = '0; reqWr = '0; reqLba = '0; reqBuffD = '0;
        hostAck = 1'b0; hostBuffW = 1'b0;
        #12;
        chk("rst.grant", 64'(grant), 64'd0);
        chk("rst.hostRd", 64'(hostRd), 64'd0);
        chk("rst.hostWr", 64'(hostWr), 64'd0);
        chk("rst.lba", 64'(hostLba), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.timeout", 64'(timeout), 64'd0);
        reset = 1'b1;
        tick();

        // 1: single read on channel 0, long ack
        reqRd = 3'b001; reqLba[31:0] = 32'h0000_0123;
        tick();
        chk("t1.hostRd", 64'(hostRd), 64'h1);
        chk("t1.lba", 64'(hostLba), 64'h123);
        chk("t1.grant", 64'(grant), 64'h1);
        hostAck = 1'b1;
        #1;
        chk("t1.ackcomb", 64'(chanAck), 64'h1);
        tick();
        chk("t1.rddrop", 64'(hostRd), 64'h0);
        reqRd = '0;
        repeat (510) tick();
        chk("t1.ackhold", 64'(chanAck), 64'h1);
        chk("t1.lbahold", 64'(hostLba), 64'h123);
        hostAck = 1'b0;
        tick();
        chk("t1.idle", 64'(busy), 64'd0);
        chk("t1.gnt0", 64'(grant), 64'd0);

        // 2: all requesters held -> strict rotation from channel 0
        reset = 1'b0; #2; reset = 1'b1;
        reqRd = 3'b111;
        do_xfer("t2a", 3'b001);
        do_xfer("t2b", 3'b010);
        do_xfer("t2c", 3'b100);
        do_xfer("t2d", 3'b001);
        reqRd = '0;

        // 3: write on channel 2, buffer routing
        reqWr = 3'b100; reqBuffD = 24'hA5_00_00;
        tick();
        chk("t3.hostWr", 64'(hostWr), 64'h4);
        chk("t3.hostRd", 64'(hostRd), 64'h0);
        hostAck = 1'b1;
        tick();
        chk("t3.buffD", 64'(hostBuffD), 64'hA5);
        hostBuffW = 1'b1;
        #1;
        chk("t3.buffW", 64'(chanBuffW), 64'h4);
        hostBuffW = 1'b0; reqWr = '0; hostAck = 1'b0;
        tick();
        chk("t3.idle", 64'(busy), 64'd0);
        hostAck = 1'b1; hostBuffW = 1'b1;
        #1;
        chk("t3.strayAck", 64'(chanAck), 64'd0);
        chk("t3.strayW", 64'(chanBuffW), 64'd0);
        hostAck = 1'b0; hostBuffW = 1'b0;

        // 4: request dropped in ISSUE -> abort
        reqRd = 3'b010;
        tick();
        chk("t4.grant", 64'(grant), 64'h2);
        reqRd = '0;
        tick();
        chk("t4.hostRd", 64'(hostRd), 64'd0);
        chk("t4.grant0", 64'(grant), 64'd0);
        chk("t4.busy", 64'(busy), 64'd0);
        hostAck = 1'b1;
        #1;
        chk("t4.lateAck", 64'(chanAck), 64'd0);
        hostAck = 1'b0;

        // 5: reset during XFER, then pending 110 -> channel 1 first
        reqRd = 3'b001; reqLba[31:0] = 32'h0000_0055;
        tick();
        chk("t5.grant", 64'(grant), 64'h1);
        hostAck = 1'b1;
        tick();
        #3;
        reset = 1'b0;
        #1;
        chk("t5.rstGrant", 64'(grant), 64'd0);
        chk("t5.rstBusy", 64'(busy), 64'd0);
        chk("t5.rstLba", 64'(hostLba), 64'd0);
        chk("t5.rstAck", 64'(chanAck), 64'd0);
        reqRd = 3'b110; hostAck = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        chk("t5.first", 64'(grant), 64'h2);
        hostAck = 1'b1;
        tick();
        reqRd = 3'b100; hostAck = 1'b0;
        tick();

        // 6: no ack in ISSUE
        reqRd = 3'b101;
        tick();
        chk("t6.grant", 64'(grant), 64'h4);
        seen = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
        repeat (15) begin
            tick();
            if (timeout) seen = 1'b1;
        end
        chk("t6.early", 64'(seen), 64'd0);
        tick();
        chk("t6.pulse", 64'(timeout), 64'd1);
        chk("t6.gnt0", 64'(grant), 64'd0);
        chk("t6.rdclr", 64'(hostRd), 64'd0);
        tick();
        chk("t6.pulse1", 64'(timeout), 64'd0);
        chk("t6.next", 64'(grant), 64'h1);
`else
        repeat (1000) begin
            tick();
            if (timeout) seen = 1'b1;
        end
        chk("t6.busy", 64'(busy), 64'd1);
        chk("t6.hostRd", 64'(hostRd), 64'h4);
        chk("t6.noTimeout", 64'(seen), 64'd0);
`endif
        reqRd = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
